// File: rtl/tile_lane_engine.sv
// tile_lane_engine: falling-tile rhythm game core with per-lane hit judging and a registered pixel colour.
module tile_lane_engine #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 157,
  parameter int GAP      = 4,
  parameter int TILE_H   = 100,
  parameter int SCREEN_H = 480,
  parameter int HIT_Y    = 380,
  parameter int STEP     = 1,
  parameter int SCORE_W  = 10
) (
  input  logic               clk_d,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [LANES-1:0]   spawn,
  input  logic [LANES-1:0]   key,
  input  logic               key_start,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               active,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         game_state,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam int PITCH = LANE_W + GAP;
  localparam logic [11:0] LANE_COL [4] = '{12'hA00, 12'hFF0, 12'h00A, 12'h0F0};
  state_t state;
  logic [LANES-1:0] valid, hit, key_q, key_edge, elig, gone;
  logic [9:0] tile_y [LANES];
  logic [9:0] next_y [LANES];
  logic start_q, start_edge, fault;
  logic [SCORE_W+3:0] score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [11:0] color;
  int px, py;
  assign key_edge = key & ~key_q;
  assign start_edge = key_start & ~start_q;
  assign game_state = state;
  assign px = int'(pixel_x);
  assign py = int'(pixel_y);
  assign score_sat = |score_sum[SCORE_W+3:SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  // Judging uses pre-advance tile_y, so a key edge and frame_tick in the same cycle see the old row.
  always_comb begin
    elig = '0;
    gone = '0;
    fault = 1'b0;
    score_sum = {4'd0, score};
    for (int i = 0; i < LANES; i++) begin
      elig[i] = valid[i] && !hit[i] && ({1'b0, tile_y[i]} + 11'(TILE_H-1) >= 11'(HIT_Y));
      gone[i] = valid[i] && ({1'b0, tile_y[i]} >= 11'(SCREEN_H));
      fault = fault | (key_edge[i] & ~elig[i]) | (gone[i] & ~hit[i]);
      score_sum = score_sum + (SCORE_W+4)'(key_edge[i] & elig[i]);
      next_y[i] = ({1'b0, tile_y[i]} + 11'(STEP)) > 11'd1023 ? 10'h3FF : tile_y[i] + 10'(STEP);
    end
  end
  always_ff @(posedge clk_d) begin
    if (rst) begin
      state <= IDLE;
      score <= '0;
      valid <= '0;
      hit <= '0;
      key_q <= '0;
      start_q <= 1'b0;
      game_over <= 1'b0;
      for (int i = 0; i < LANES; i++) tile_y[i] <= '0;
    end else begin
      key_q <= key;
      start_q <= key_start;
      game_over <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          state <= PLAY;
          score <= '0;
          valid <= '0;
          hit <= '0;
        end
        PLAY: if (fault) begin
          state <= OVER;
          game_over <= 1'b1;
        end else begin
          score <= score_sat;
          for (int i = 0; i < LANES; i++) begin
            if (!valid[i]) begin
              if (spawn[i]) begin
                valid[i] <= 1'b1;
                hit[i] <= 1'b0;
                tile_y[i] <= '0;
              end
            end else if (gone[i]) begin
              valid[i] <= 1'b0;
              hit[i] <= 1'b0;
            end else begin
              if (key_edge[i]) hit[i] <= 1'b1;
              if (frame_tick) tile_y[i] <= next_y[i];
            end
          end
        end
        OVER: if (start_edge) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    color = state == IDLE ? 12'h001 : state == OVER ? 12'h010 : 12'h000;
    for (int i = 0; i < LANES; i++) begin
      if (state == PLAY && i < LANES-1 && px >= i*PITCH+LANE_W && px < (i+1)*PITCH) color = 12'h777;
      if (state != IDLE && valid[i] && px >= i*PITCH && px < i*PITCH+LANE_W &&
          py >= int'(tile_y[i]) && py < int'(tile_y[i])+TILE_H)
        color = state == OVER ? 12'hF03 : hit[i] ? 12'h000 : LANE_COL[i[1:0]];
    end
  end
  always_ff @(posedge clk_d) begin
    if (rst) {red, green, blue} <= 12'h000;
    else {red, green, blue} <= active ? color : 12'h000;
  end
endmodule

// File: tb/tb_tile_lane_engine.sv
// tb_tile_lane_engine: directed scenarios plus randomized play, checked every cycle against a behavioural model.
module tb_tile_lane_engine;
  localparam int LANES = 4, LANE_W = 157, GAP = 4, TILE_H = 100, SCREEN_H = 480, HIT_Y = 380, STEP = 1;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic clk_d, rst, frame_tick, key_start, active;
  logic [LANES-1:0] spawn, key;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] red, green, blue;
  logic [SW-1:0] score;
  logic [1:0] game_state;
  logic game_over;
  int n_pass = 0, n_total = 0;
  bit rnd_pix = 1;
  int m_state, m_score, exp_rgb, exp_go;
  int m_valid [LANES], m_hit [LANES], m_y [LANES], m_kprev [LANES];
  int m_sprev;

  tile_lane_engine #(.LANES(LANES), .LANE_W(LANE_W), .GAP(GAP), .TILE_H(TILE_H), .SCREEN_H(SCREEN_H),
    .HIT_Y(HIT_Y), .STEP(STEP), .SCORE_W(SW)) dut (
    .clk_d(clk_d), .rst(rst), .frame_tick(frame_tick), .spawn(spawn), .key(key), .key_start(key_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active), .red(red), .green(green), .blue(blue),
    .score(score), .game_state(game_state), .game_over(game_over));

  initial clk_d = 0;
  always #5 clk_d = ~clk_d;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lane_col(int l);
    case (l % 4)
      0: return 'hA00;
      1: return 'hFF0;
      2: return 'h00A;
      default: return 'h0F0;
    endcase
  endfunction

  function automatic int model_colour();
    int px, py, l, o, c;
    if (m_state == 0) return 'h001;
    px = int'(pixel_x);
    py = int'(pixel_y);
    c = (m_state == 2) ? 'h010 : 0;
    l = px / (LANE_W + GAP);
    o = px % (LANE_W + GAP);
    if (l < LANES && o < LANE_W) begin
      if (m_valid[l] != 0 && py >= m_y[l] && py < m_y[l] + TILE_H)
        c = (m_state == 2) ? 'hF03 : (m_hit[l] != 0) ? 0 : lane_col(l);
    end else if (l < LANES - 1 && m_state == 1) c = 'h777;
    return c;
  endfunction

  task automatic model_step();
    int n, flt, se, elig;
    int ke [LANES];
    exp_rgb = active ? model_colour() : 0;
    exp_go = 0;
    se = (key_start && m_sprev == 0) ? 1 : 0;
    for (int i = 0; i < LANES; i++) ke[i] = (key[i] && m_kprev[i] == 0) ? 1 : 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_sprev = 0; exp_rgb = 0;
      for (int i = 0; i < LANES; i++) begin m_valid[i] = 0; m_hit[i] = 0; m_y[i] = 0; m_kprev[i] = 0; end
      return;
    end
    m_sprev = key_start;
    for (int i = 0; i < LANES; i++) m_kprev[i] = key[i];
    if (m_state == 0) begin
      if (se != 0) begin
        m_state = 1; m_score = 0;
        for (int i = 0; i < LANES; i++) begin m_valid[i] = 0; m_hit[i] = 0; end
      end
    end else if (m_state == 2) begin
      if (se != 0) m_state = 0;
    end else begin
      n = 0; flt = 0;
      for (int i = 0; i < LANES; i++) begin
        elig = (m_valid[i] != 0 && m_hit[i] == 0 && m_y[i] + TILE_H - 1 >= HIT_Y) ? 1 : 0;
        if (ke[i] != 0) begin if (elig != 0) n++; else flt = 1; end
        if (m_valid[i] != 0 && m_y[i] >= SCREEN_H && m_hit[i] == 0) flt = 1;
      end
      if (flt != 0) begin
        m_state = 2; exp_go = 1;
      end else begin
        m_score = (m_score + n > SMAX) ? SMAX : m_score + n;
        for (int i = 0; i < LANES; i++) begin
          if (m_valid[i] == 0) begin
            if (spawn[i]) begin m_valid[i] = 1; m_hit[i] = 0; m_y[i] = 0; end
          end else if (m_y[i] >= SCREEN_H) begin
            m_valid[i] = 0; m_hit[i] = 0;
          end else begin
            if (ke[i] != 0) m_hit[i] = 1;
            if (frame_tick) m_y[i] = (m_y[i] + STEP > 1023) ? 1023 : m_y[i] + STEP;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    if (rnd_pix) begin
      pixel_x = 10'($urandom_range(0, 700));
      pixel_y = 10'($urandom_range(0, 520));
      active = ($urandom_range(0, 7) != 0);
    end
    model_step();
    @(posedge clk_d);
    #1;
    chk("state", int'(game_state), m_state);
    chk("score", int'(score), m_score);
    chk("game_over", int'(game_over), exp_go);
    chk("rgb", int'({red, green, blue}), exp_rgb);
  endtask

  task automatic ticks(int n);
    frame_tick = 1;
    repeat (n) cyc();
    frame_tick = 0;
  endtask

  task automatic press(logic [LANES-1:0] k);
    key = k; cyc();
    key = '0; cyc();
  endtask

  task automatic start_pulse();
    key_start = 1; cyc();
    key_start = 0; cyc();
  endtask

  task automatic pix(int x, int y, logic a, int exp, string name);
    rnd_pix = 0;
    pixel_x = 10'(x); pixel_y = 10'(y); active = a;
    cyc();
    chk(name, int'({red, green, blue}), exp);
    rnd_pix = 1;
  endtask

  task automatic spawn_lanes(logic [LANES-1:0] s);
    spawn = s; cyc();
    spawn = '0;
  endtask

  initial begin
    rst = 1; frame_tick = 0; key_start = 0; spawn = '0; key = '0;
    pixel_x = '0; pixel_y = '0; active = 0;
    repeat (2) cyc();
    rst = 0;
    chk("reset_state", int'(game_state), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_rgb", int'({red, green, blue}), 0);
    start_pulse();
    chk("idle_to_play", int'(game_state), 1);
    // lane 0 falls to the hit zone and is struck with a held key
    spawn_lanes(4'b0001);
    ticks(380);
    pix(10, 380, 1, 'hA00, "lane0_tile_row380");
    pix(10, 379, 1, 'h000, "above_tile");
    key = 4'b0001; cyc();
    chk("hit_score", int'(score), 1);
    repeat (9) cyc();
    key = '0; cyc();
    chk("held_key_once", int'(score), 1);
    chk("held_key_state", int'(game_state), 1);
    ticks(100);
    cyc();
    chk("hit_tile_cleared_state", int'(game_state), 1);
    pix(10, 470, 1, 'h000, "cleared_tile_pixel");
    // two lanes hit together, then a mixed good/bad pair
    spawn_lanes(4'b1001);
    ticks(300);
    press(4'b1001);
    chk("dual_hit_score", int'(score), 3);
    ticks(181);
    cyc();
    spawn_lanes(4'b1001);
    ticks(300);
    key = 4'b0011; cyc();
    chk("mixed_fault_state", int'(game_state), 2);
    chk("mixed_fault_pulse", int'(game_over), 1);
    chk("mixed_fault_score", int'(score), 3);
    key = '0; cyc();
    chk("pulse_one_cycle", int'(game_over), 0);
    pix(10, 350, 1, 'hF03, "over_tile");
    pix(10, 10, 1, 'h010, "over_bg");
    start_pulse();
    chk("over_to_idle", int'(game_state), 0);
    chk("idle_score_held", int'(score), 3);
    pix(300, 200, 1, 'h001, "idle_colour");
    start_pulse();
    chk("restart_score", int'(score), 0);
    // early key press on a high tile
    spawn_lanes(4'b0010);
    ticks(50);
    key = 4'b0010; cyc();
    chk("early_key_state", int'(game_state), 2);
    chk("early_key_pulse", int'(game_over), 1);
    chk("early_key_score", int'(score), 0);
    key = '0; cyc();
    start_pulse(); start_pulse();
    // missed tile leaves the screen
    spawn_lanes(4'b0100);
    ticks(480);
    chk("miss_at_480_pre", int'(game_state), 1);
    cyc();
    chk("miss_state", int'(game_state), 2);
    chk("miss_pulse", int'(game_over), 1);
    start_pulse(); start_pulse();
    // score saturation
    for (int r = 1; r <= 4; r++) begin
      spawn_lanes(4'b1111);
      ticks(300);
      press(4'b1111);
      chk("sat_score", int'(score), (4 * r > SMAX) ? SMAX : 4 * r);
      ticks(181);
      cyc();
    end
    pix(158, 10, 1, 'h777, "separator");
    pix(158, 10, 0, 'h000, "inactive");
    rst = 1; cyc(); rst = 0;
    chk("midplay_rst_state", int'(game_state), 0);
    chk("midplay_rst_score", int'(score), 0);
    // randomized play
    for (int c = 0; c < 12000; c++) begin
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 199) == 0) key_start = ~key_start;
      frame_tick = 1'($urandom_range(0, 1));
      for (int l = 0; l < LANES; l++) begin
        spawn[l] = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 599) == 0) key[l] = ~key[l];
      end
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tile_lane_engine.md
TILE_LANE_ENGINE -- requirements
Module: tile_lane_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be clk_d and the reset port SHALL be rst.
REQ-002 Parameter LANES, 4, number of tile lanes (1..8).
REQ-003 Parameter LANE_W, 157, lane width in pixels.
REQ-004 Parameter GAP, 4, separator width in pixels between adjacent lanes.
REQ-005 Parameter TILE_H, 100, tile height in rows.
REQ-006 Parameter SCREEN_H, 480, active rows.
REQ-007 Parameter HIT_Y, 380, first row of the hit zone.
REQ-008 Parameter STEP, 1, rows a tile falls per frame_tick.
REQ-009 Parameter SCORE_W, 10, score width.
REQ-010 clk_d  in  1  pixel clock.
REQ-011 rst  in  1  synchronous active-high reset.
REQ-012 frame_tick  in  1  one-cycle pulse once per frame, advances tiles.
REQ-013 spawn  in  LANES  per-lane tile spawn request, level-sampled each cycle.
REQ-014 key  in  LANES  per-lane key level, debounced upstream.
REQ-015 key_start  in  1  start/restart key level.
REQ-016 pixel_x, pixel_y  in  10 each  current scan position.
REQ-017 active  in  1  scan position is inside the visible area.
REQ-018 red, green, blue  out  4 each  registered pixel colour.
REQ-019 score  out  SCORE_W  hit count.
REQ-020 game_state  out  2  0=IDLE, 1=PLAY, 2=OVER.
REQ-021 game_over  out  1  one-cycle pulse on entry to OVER.

Function
REQ-022 key and key_start SHALL be rising-edge detected internally (previous-level register); a level held high SHALL count once.
REQ-023 Per lane state SHALL be valid, hit and tile_y (10 bits, top row); the tile covers rows tile_y..tile_y+TILE_H-1.
REQ-024 IDLE->PLAY on a key_start edge: score cleared, all lanes valid=0, hit=0.
REQ-025 In PLAY, spawn[i] with lane i not valid SHALL load tile_y=0, valid=1, hit=0 the next cycle; spawn on a valid lane SHALL be ignored.
REQ-026 In PLAY, on frame_tick every valid tile SHALL advance tile_y by STEP, computed 11 bits wide with no wrap.
REQ-027 A tile is eligible when valid, not hit, and tile_y+TILE_H-1 >= HIT_Y.
REQ-028 A key[i] edge on an eligible lane-i tile SHALL set hit=1 and increment score, saturating at 2^SCORE_W-1.
REQ-029 A key[i] edge with no eligible tile in lane i is a fault.
REQ-030 A valid tile with tile_y >= SCREEN_H SHALL be cleared if hit; if not hit, this is a fault.
REQ-031 Same-cycle key edges on several lanes SHALL be judged independently; if any fault occurs in the cycle, no score update that cycle.
REQ-032 Key edges coinciding with frame_tick SHALL be judged against pre-advance tile_y.
REQ-033 Any fault in PLAY SHALL move to OVER next cycle and pulse game_over for exactly one cycle; lanes freeze and score holds.
REQ-034 OVER->IDLE on a key_start edge; score holds until the next IDLE->PLAY.
REQ-035 Lane i spans x in [i*(LANE_W+GAP), i*(LANE_W+GAP)+LANE_W-1]; the GAP columns after lanes 0..LANES-2 are separators.
REQ-036 Colour SHALL be registered, one cycle after pixel_x/pixel_y/active.
REQ-037 When active=0, colour SHALL be 000.
REQ-038 PLAY colour priority: unhit tile pixel uses the lane colour (i mod 4: A00, FF0, 00A, 0F0); hit tile pixel 000; separator 777; otherwise 000.
REQ-039 OVER colour (also frozen) SHALL be F03 within the frozen tiles' pixels and 010 elsewhere; IDLE colour SHALL be 001.

Reset
REQ-040 rst SHALL force IDLE, score=0, all lanes valid=0/hit=0/tile_y=0, edge registers=0, red/green/blue=0, game_over=0; rst overrides all same-cycle events, including mid-PLAY.

Verification
REQ-041 rst, key_start edge, spawn[0] -> lane 0 tile_y=0; after 380 frame_ticks tile_y=380 -> key[0] edge -> score=1, no fault.
REQ-042 PLAY, lane 1 tile_y=50 (not eligible), key[1] edge -> game_over pulses 1 cycle, game_state=2, score unchanged.
REQ-043 Unhit lane 2 tile reaches tile_y=480 -> OVER; hit tile reaching 480 -> cleared, game_state stays 1.
REQ-044 Eligible tiles in lanes 0 and 3, key[0] and key[1] edges same cycle -> OVER, score unchanged; key[0] and key[3] only -> score +2.
REQ-045 score at 1023 with SCORE_W=10, valid hit -> score stays 1023; key held high 10 cycles counts once.
REQ-046 pixel_x=158, pixel_y=10, active=1 in PLAY -> next cycle RGB=777; active=0 -> 000; rst asserted mid-PLAY -> next cycle game_state=0, score=0.
